// File: rtl/handshake_pkg.sv
// handshake_pkg
//   Definitions shared by the req/ack reader and its FIFO.
//   - rstate_t  : 2-bit reader FSM state (R_IDLE, R_ACK, R_CAP, R_REL)
//   - HS_DATA_W : default data width of the handshake word
package handshake_pkg;

  localparam int HS_DATA_W = 8;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACK  = 2'd1,
    R_CAP  = 2'd2,
    R_REL  = 2'd3
  } rstate_t;

endpackage

// File: rtl/hs_fifo.sv
// hs_fifo
//   Show-ahead FIFO. The head entry is always visible on 'head'. A push and
//   a pop in the same cycle leave occupancy unchanged and advance both
//   pointers, at any occupancy including full.
//   Parameters: WIDTH (word width), DEPTH (entries, power of two, >= 2)
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   asynchronous, active-low reset
//     push       in   write push_data at the tail
//     push_data  in   word to write
//     pop        in   drop the head entry (ignored when empty)
//     head       out  head entry (don't-care when empty)
//     empty      out  occupancy == 0
//     full       out  occupancy == DEPTH
module hs_fifo
  import handshake_pkg::*;
#(
  parameter int WIDTH = HS_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_MAX);
  assign head   = mem[rd_ptr];
  assign do_pop = pop && !empty;

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reader.sv
// reader
//   Receiving end of a four-phase req/ack handshake. Acknowledges a request,
//   captures the writer's word in its single data cycle and queues it in a
//   show-ahead FIFO drained by a valid/ready consumer. 'ack' is withheld
//   while the FIFO is full, holding the writer off.
//   Optional feature macro: READER_STATS_EN adds the 16-bit xfer_count
//   port/register counting captured words (wraps at 16'hFFFF).
//   Ports:
//     clk         in   rising-edge clock shared with the writer
//     reset       in   asynchronous, active-low reset
//     req         in   writer request
//     d           in   writer data, valid in the capture cycle
//     ack         out  registered acknowledge
//     dout        out  FIFO head word
//     dvalid      out  FIFO non-empty
//     dready      in   consumer accepts dout when dvalid && dready
//     xfer_count  out  captured-word count (READER_STATS_EN only)
module reader
  import handshake_pkg::*;
#(
  parameter int WIDTH = HS_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [WIDTH-1:0] d,
  output logic             ack,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             dready
`ifdef READER_STATS_EN
  ,
  output logic [15:0]      xfer_count
`endif
);

  rstate_t state;
  logic    push;
  logic    pop;
  logic    empty;
  logic    full;

  // One word is in flight at a time and fullness is only checked in R_IDLE,
  // so the R_CAP push can never land on a full FIFO.
  assign push   = (state == R_CAP);
  assign dvalid = !empty;
  assign pop    = dvalid && dready;

  // ack is registered alongside the state: high from R_ACK through R_REL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= R_IDLE;
      ack   <= 1'b0;
    end else begin
      case (state)
        R_IDLE: begin
          if (req && !full) begin
            state <= R_ACK;
            ack   <= 1'b1;
          end
        end
        R_ACK: begin
          state <= R_CAP;
        end
        R_CAP: begin
          state <= R_REL;
        end
        R_REL: begin
          if (!req) begin
            state <= R_IDLE;
            ack   <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef READER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_count <= 16'd0;
    end else if (push) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end
`endif

  hs_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(d),
    .pop      (pop),
    .head     (dout),
    .empty    (empty),
    .full     (full)
  );

endmodule

// File: tb/tb_reader.sv
// tb_reader
//   Self-checking bench for reader. A writer task drives the four-phase
//   handshake and queues each word it presents; a monitor pops the queue
//   whenever the DUT hands a word to the consumer and compares it.
module tb_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk    = 1'b0;
  logic             reset  = 1'b0;
  logic             req    = 1'b0;
  logic             dready = 1'b0;
  logic [WIDTH-1:0] d      = '0;
  logic             ack;
  logic             dvalid;
  logic [WIDTH-1:0] dout;
`ifdef READER_STATS_EN
  logic [15:0]      xfer_count;
`endif

  int               checks = 0;
  int               errors = 0;
  int               pops   = 0;
  logic [WIDTH-1:0] sb[$];

  always #5 clk = ~clk;

  reader #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .d         (d),
    .ack       (ack),
    .dout      (dout),
    .dvalid    (dvalid),
    .dready    (dready)
`ifdef READER_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Writer side of one transfer; caller is just after a rising edge.
  // Data is presented only in the R_CAP cycle; junk otherwise.
  task automatic apply_stimulus(input logic [WIDTH-1:0] data, input bit pop_in_cap);
    int n;
    bit got;
    req = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      step();
      n++;
      got = ack;
    end
    if (!got) begin
      check_output("ack_timeout", {31'd0, ack}, 32'd1);
      req = 1'b0;
      return;
    end
    step();
    d = data;
    sb.push_back(data);
    if (pop_in_cap) dready = 1'b1;
    step();
    req = 1'b0;
    d   = 8'hEE;
    if (pop_in_cap) dready = 1'b0;
    n = 0;
    while (ack && n < 50) begin
      step();
      n++;
    end
    if (ack) check_output("ack_release_timeout", {31'd0, ack}, 32'd0);
  endtask

  // Monitor: every accepted output word must match the queue head.
  always @(negedge clk) begin
    if (reset && dvalid && dready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got %0h expected none at %0t", dout, $time);
      end else begin
        check_output("dout", {24'd0, dout}, {24'd0, sb.pop_front()});
        pops++;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ackc;
    int dvc;
    logic [WIDTH-1:0] bpv[4];
    logic [WIDTH-1:0] wrapv[10];
    int n;
    bpv   = '{8'h11, 8'h22, 8'h33, 8'h44};
    wrapv = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'hF0, 8'h0F};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ack", {31'd0, ack}, 32'd0);
    check_output("reset_dvalid", {31'd0, dvalid}, 32'd0);
`ifdef READER_STATS_EN
    check_output("reset_xfer_count", {16'd0, xfer_count}, 32'd0);
`endif
    reset = 1'b1;
    step();

    // Single transfer: ack high R_ACK..R_REL, word visible for one cycle
    $display("[TB] single transfer");
    dready = 1'b1;
    ackc = 0;
    dvc  = 0;
    fork
      apply_stimulus(8'h5A, 1'b0);
      begin
        repeat (12) begin
          @(negedge clk);
          ackc += int'(ack);
          dvc  += int'(dvalid);
        end
      end
    join
    step();
    check_output("single_ack_cycles", ackc, 32'd3);
    check_output("single_dvalid_cycles", dvc, 32'd1);
    check_output("single_drained", sb.size(), 32'd0);
`ifdef READER_STATS_EN
    check_output("single_xfer_count", {16'd0, xfer_count}, 32'd1);
`endif

    // Back-pressure: fill, fifth request stalls until one pop
    $display("[TB] back-pressure");
    dready = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(bpv[i], 1'b0);
    check_output("bp_dvalid", {31'd0, dvalid}, 32'd1);
    fork
      apply_stimulus(8'h55, 1'b0);
      begin
        repeat (4) begin
          @(negedge clk);
          check_output("bp_ack_held", {31'd0, ack}, 32'd0);
        end
        @(posedge clk);
        #1 dready = 1'b1;
        step();
        dready = 1'b0;
        step();
        check_output("bp_ack_after_pop", {31'd0, ack}, 32'd1);
      end
    join
    check_output("bp_queue_depth", sb.size(), 32'd4);

    // Push and pop in the same edge: occupancy must not change
    $display("[TB] simultaneous push/pop");
    dready = 1'b1;
    step();
    dready = 1'b0;
    apply_stimulus(8'hC6, 1'b1);
    apply_stimulus(8'hD7, 1'b0);
    fork
      apply_stimulus(8'hE8, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check_output("pp_full_ack_held", {31'd0, ack}, 32'd0);
        end
        @(posedge clk);
        #1 dready = 1'b1;
      end
    join
    repeat (8) step();
    check_output("pp_drained", sb.size(), 32'd0);
    check_output("pp_dvalid_empty", {31'd0, dvalid}, 32'd0);

    // Pointer wrap with back-to-back transfers
    $display("[TB] pointer wrap");
    reset = 1'b0;
    step();
    sb.delete();
    reset = 1'b1;
    step();
    pops = 0;
    dready = 1'b1;
    for (int i = 0; i < 10; i++) apply_stimulus(wrapv[i], 1'b0);
    repeat (4) step();
    check_output("wrap_pops", pops, 32'd10);
    check_output("wrap_drained", sb.size(), 32'd0);
`ifdef READER_STATS_EN
    check_output("wrap_xfer_count", {16'd0, xfer_count}, 32'd10);
`endif

    // Reset during R_CAP with a word already queued
    $display("[TB] reset mid-transfer");
    dready = 1'b0;
    apply_stimulus(8'h77, 1'b0);
    req = 1'b1;
    n = 0;
    while (!ack && n < 20) begin
      step();
      n++;
    end
    check_output("mr_ack_seen", {31'd0, ack}, 32'd1);
    step();
    d = 8'h99;
    #2 reset = 1'b0;
    #1;
    check_output("mr_ack_async", {31'd0, ack}, 32'd0);
    check_output("mr_dvalid_async", {31'd0, dvalid}, 32'd0);
    sb.delete();
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("mr_reack", {31'd0, ack}, 32'd1);
    step();
    d = 8'h3C;
    sb.push_back(8'h3C);
    step();
    req = 1'b0;
    d   = 8'hEE;
    n = 0;
    while (ack && n < 20) begin
      step();
      n++;
    end
    pops = 0;
    dready = 1'b1;
    repeat (3) step();
    check_output("mr_pops", pops, 32'd1);
    check_output("mr_drained", sb.size(), 32'd0);
`ifdef READER_STATS_EN
    check_output("mr_xfer_count", {16'd0, xfer_count}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
